// File: rtl/id_exe_pipe_pkg.sv
// Shared constants and payload sizing for the decode-to-execute pipeline register.
// The payload bundle order is {pc, op1, op2, alu_op, we, waddr}.
package id_exe_pipe_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int ALUOP_W_DEF    = 8;

  localparam logic [ALUOP_W_DEF-1:0]    NOP           = 8'h00;
  localparam logic [XLEN_DEF-1:0]       ZERO_WORD     = '0;
  localparam logic [REG_ADDR_W_DEF-1:0] ZERO_REG      = '0;
  localparam logic                      WRITE_DISABLE = 1'b0;

  function automatic int payload_width(input int xlen, input int reg_addr_w, input int aluop_w);
    return 3 * xlen + aluop_w + 1 + reg_addr_w;
  endfunction

endpackage

// File: rtl/id_exe_pipe_skid_buf.sv
// Generic valid/ready holding register: either a 2-entry skid buffer with a
// registered ready, or a single entry with combinational ready.
module id_exe_pipe_skid_buf #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] BUBBLE  = '0,
  parameter bit               SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_vld;
  logic [WIDTH-1:0] main_data;
  logic             accept;
  logic             fire;
  logic             main_load;

  // A handshake during a clear cycle is void, so it never reaches storage.
  assign accept    = in_valid & in_ready & ~clr;
  assign fire      = main_vld & out_ready;
  assign main_load = ~main_vld | fire;
  assign out_valid = main_vld;
  assign out_data  = main_data;

  if (SKID_EN) begin : g_skid
    logic             skid_vld;
    logic [WIDTH-1:0] skid_data;

    assign in_ready = ~skid_vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_vld  <= 1'b0;
        main_data <= BUBBLE;
        skid_vld  <= 1'b0;
        skid_data <= BUBBLE;
      end else if (clr) begin
        main_vld  <= 1'b0;
        main_data <= BUBBLE;
        skid_vld  <= 1'b0;
        skid_data <= BUBBLE;
      end else begin
        if (main_load) begin
          if (skid_vld) begin
            main_vld  <= 1'b1;
            main_data <= skid_data;
          end else if (accept) begin
            main_vld  <= 1'b1;
            main_data <= in_data;
          end else begin
            main_vld  <= 1'b0;
            main_data <= BUBBLE;
          end
        end
        // accept requires an empty skid, so a skid drain never coincides with a skid fill.
        if (main_load && skid_vld) begin
          skid_vld <= 1'b0;
        end else if (!main_load && accept) begin
          skid_vld  <= 1'b1;
          skid_data <= in_data;
        end
      end
    end
  end else begin : g_single
    assign in_ready = ~main_vld | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_vld  <= 1'b0;
        main_data <= BUBBLE;
      end else if (clr) begin
        main_vld  <= 1'b0;
        main_data <= BUBBLE;
      end else if (main_load) begin
        if (accept) begin
          main_vld  <= 1'b1;
          main_data <= in_data;
        end else begin
          main_vld  <= 1'b0;
          main_data <= BUBBLE;
        end
      end
    end
  end

endmodule

// File: rtl/id_exe_pipe.sv
// Decode-to-execute pipeline register with valid/ready handshake, flush,
// optional skid entry and a saturating downstream-stall counter.
module id_exe_pipe
  import id_exe_pipe_pkg::*;
#(
  parameter int                 XLEN       = XLEN_DEF,
  parameter int                 REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int                 ALUOP_W    = ALUOP_W_DEF,
  parameter logic [ALUOP_W-1:0] NOP_OP     = ALUOP_W'(NOP),
  parameter bit                 SKID_EN    = 1'b1,
  parameter int                 CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [XLEN-1:0]       op1_i,
  input  logic [XLEN-1:0]       op2_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [ALUOP_W-1:0]    aluOp_i,
  input  logic                  reg_we_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       op1_o,
  output logic [XLEN-1:0]       op2_o,
  output logic [XLEN-1:0]       pc_o,
  output logic [ALUOP_W-1:0]    aluOp_o,
  output logic                  reg_we_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int PW = payload_width(XLEN, REG_ADDR_W, ALUOP_W);

  // An empty stage presents this bundle, which keeps reg_we low whenever out_valid is low.
  localparam logic [PW-1:0] BUBBLE = {XLEN'(ZERO_WORD), XLEN'(ZERO_WORD), XLEN'(ZERO_WORD),
                                      NOP_OP, WRITE_DISABLE, REG_ADDR_W'(ZERO_REG)};

  logic [PW-1:0]    in_bundle;
  logic [PW-1:0]    out_bundle;
  logic [CNT_W-1:0] stall_cnt;

  assign in_bundle = {pc_i, op1_i, op2_i, aluOp_i, reg_we_i, reg_waddr_i};
  assign {pc_o, op1_o, op2_o, aluOp_o, reg_we_o, reg_waddr_o} = out_bundle;

  id_exe_pipe_skid_buf #(
    .WIDTH   (PW),
    .BUBBLE  (BUBBLE),
    .SKID_EN (SKID_EN)
  ) u_skid_buf (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .clr       (flush_i),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (in_bundle),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (out_bundle)
  );

  // Counts every cycle exe refuses a valid instruction; flush does not clear it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;

  a_we_implies_valid : assert property (@(posedge clk_i) disable iff (!rst_i)
    reg_we_o |-> out_valid_o);

  a_hold_under_stall : assert property (@(posedge clk_i) disable iff (!rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_bundle)));

endmodule

// File: tb/tb_id_exe_pipe.sv
// Bench for id_exe_pipe: a skid instance (4-bit counter) and a single-entry instance
// share stimulus and are each compared against an abstract FIFO model every cycle.
module tb_id_exe_pipe;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int AW   = 8;
  localparam int PW   = 3 * XLEN + AW + 1 + RW;
  localparam int CW0  = 4;
  localparam int CW1  = 16;
  localparam logic [PW-1:0] BUB = '0;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic out_ready_i = 1'b0;
  logic [XLEN-1:0] op1_i = '0, op2_i = '0, pc_i = '0;
  logic [AW-1:0] aluop_i = '0;
  logic reg_we_i = 1'b0;
  logic [RW-1:0] reg_waddr_i = '0;

  logic rdy0, vld0, o0_we, rdy1, vld1, o1_we;
  logic [XLEN-1:0] o0_op1, o0_op2, o0_pc, o1_op1, o1_op2, o1_pc;
  logic [AW-1:0] o0_alu, o1_alu;
  logic [RW-1:0] o0_wa, o1_wa;
  logic [CW0-1:0] cnt0_o;
  logic [CW1-1:0] cnt1_o;
  logic [PW-1:0] obs0, obs1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_exe_pipe #(.SKID_EN(1'b1), .CNT_W(CW0)) u_skid (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(rdy0),
    .op1_i(op1_i), .op2_i(op2_i), .pc_i(pc_i), .aluOp_i(aluop_i), .reg_we_i(reg_we_i),
    .reg_waddr_i(reg_waddr_i), .out_valid_o(vld0), .out_ready_i(out_ready_i), .op1_o(o0_op1),
    .op2_o(o0_op2), .pc_o(o0_pc), .aluOp_o(o0_alu), .reg_we_o(o0_we), .reg_waddr_o(o0_wa),
    .stall_cnt_o(cnt0_o));

  id_exe_pipe #(.SKID_EN(1'b0), .CNT_W(CW1)) u_single (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(rdy1),
    .op1_i(op1_i), .op2_i(op2_i), .pc_i(pc_i), .aluOp_i(aluop_i), .reg_we_i(reg_we_i),
    .reg_waddr_i(reg_waddr_i), .out_valid_o(vld1), .out_ready_i(out_ready_i), .op1_o(o1_op1),
    .op2_o(o1_op2), .pc_o(o1_pc), .aluOp_o(o1_alu), .reg_we_o(o1_we), .reg_waddr_o(o1_wa),
    .stall_cnt_o(cnt1_o));

  assign obs0 = {o0_pc, o0_op1, o0_op2, o0_alu, o0_we, o0_wa};
  assign obs1 = {o1_pc, o1_op1, o1_op2, o1_alu, o1_we, o1_wa};

  // Reference model: each instance is an ordered queue of held instructions
  // (capacity 2 with skid, 1 without) plus a saturating stall tally.
  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];
  int unsigned mcnt0 = 0, mcnt1 = 0;
  bit ma0, ma1;

  function automatic bit exp_rdy0();
    return q0.size() < 2;
  endfunction

  function automatic bit exp_rdy1();
    return (q1.size() == 0) || out_ready_i;
  endfunction

  function automatic logic [PW-1:0] exp_out0();
    return (q0.size() > 0) ? q0[0] : BUB;
  endfunction

  function automatic logic [PW-1:0] exp_out1();
    return (q1.size() > 0) ? q1[0] : BUB;
  endfunction

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      q0.delete();
      q1.delete();
      mcnt0 = 0;
      mcnt1 = 0;
    end else begin
      ma0 = in_valid_i && exp_rdy0();
      ma1 = in_valid_i && exp_rdy1();
      if (q0.size() > 0 && !out_ready_i && mcnt0 < 15) mcnt0++;
      if (q1.size() > 0 && !out_ready_i && mcnt1 < 65535) mcnt1++;
      if (flush_i) begin
        q0.delete();
        q1.delete();
      end else begin
        if (q0.size() > 0 && out_ready_i) void'(q0.pop_front());
        if (q1.size() > 0 && out_ready_i) void'(q1.pop_front());
        if (ma0) q0.push_back({pc_i, op1_i, op2_i, aluop_i, reg_we_i, reg_waddr_i});
        if (ma1) q1.push_back({pc_i, op1_i, op2_i, aluop_i, reg_we_i, reg_waddr_i});
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] p, input bit we);
    in_valid_i  = v;
    op1_i       = a;
    pc_i        = p;
    op2_i       = $urandom;
    aluop_i     = 8'($urandom_range(1, 255));
    reg_we_i    = we;
    reg_waddr_i = 5'($urandom);
  endtask

  task automatic do_reset();
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    rst_i       = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL rst_vld0 got %b want 0", vld0); end
    checks++; if (o0_alu !== 8'h00) begin errors++; $display("FAIL rst_alu0 got %h want 00", o0_alu); end
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL rst_vld1 got %b want 0", vld1); end
    rst_i = 1'b1;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_rdy0 got %b want 1", rdy0); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL rst_rdy1 got %b want 1", rdy1); end
    checks++; if (o0_we !== 1'b0 || o1_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b%b want 00", o0_we, o1_we); end
    checks++; if (cnt0_o !== 4'd0 || cnt1_o !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0", cnt0_o, cnt1_o); end
    checks++; if (obs0 !== BUB || obs1 !== BUB) begin errors++; $display("FAIL rst_payload got %h / %h want bubble", obs0, obs1); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 32'h100 + 32'(4 * i), 1'b1);
      @(negedge clk);
      checks++; if (vld0 !== 1'b1 || o0_op1 !== 32'(i) || o0_pc !== 32'h100 + 32'(4 * i)) begin
        errors++; $display("FAIL stream_skid[%0d] got v=%b op1=%0h pc=%0h want op1=%0h", i, vld0, o0_op1, o0_pc, i); end
      checks++; if (vld1 !== 1'b1 || o1_op1 !== 32'(i) || o1_pc !== 32'h100 + 32'(4 * i)) begin
        errors++; $display("FAIL stream_single[%0d] got v=%b op1=%0h pc=%0h want op1=%0h", i, vld1, o1_op1, o1_pc, i); end
      checks++; if (obs0 !== exp_out0()) begin errors++; $display("FAIL stream_bundle[%0d] got %h want %h", i, obs0, exp_out0()); end
    end
    in_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (vld0 !== 1'b0 || vld1 !== 1'b0 || o0_we !== 1'b0) begin
      errors++; $display("FAIL stream_drain got v=%b%b we=%b want 000", vld0, vld1, o0_we); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rec[$];
    bit drop;
    do_reset();
    drive(1'b1, 32'hA, 32'h200, 1'b1);
    @(negedge clk);
    checks++; if (vld0 !== 1'b1 || o0_op1 !== 32'hA || rdy0 !== 1'b1) begin
      errors++; $display("FAIL bp_a got v=%b op1=%h rdy=%b want 1/a/1", vld0, o0_op1, rdy0); end
    drive(1'b1, 32'hB, 32'h204, 1'b1);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0 || o0_op1 !== 32'hA) begin
      errors++; $display("FAIL bp_full got rdy=%b op1=%h want 0/a", rdy0, o0_op1); end
    checks++; if (rdy1 !== 1'b0 || o1_op1 !== 32'hA) begin
      errors++; $display("FAIL bp_single got rdy=%b op1=%h want 0/a", rdy1, o1_op1); end
    drive(1'b1, 32'hC, 32'h208, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checks++; if (rdy0 !== 1'b0 || vld0 !== 1'b1 || o0_op1 !== 32'hA) begin
        errors++; $display("FAIL bp_hold got rdy=%b v=%b op1=%h want 0/1/a", rdy0, vld0, o0_op1); end
    end
    checks++; if (cnt0_o !== 4'd4) begin errors++; $display("FAIL bp_stall got %0d want 4", cnt0_o); end
    out_ready_i = 1'b1;
    rec.push_back(o0_op1);
    drop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (obs1 !== exp_out1() || rdy1 !== exp_rdy1()) begin
        errors++; $display("FAIL bp_model1[%0d] got %h rdy=%b want %h", k, obs1, rdy1, exp_out1()); end
      if (vld0) rec.push_back(o0_op1);
      if (drop) in_valid_i = 1'b0;
      else if (in_valid_i && rdy0) drop = 1'b1;
    end
    checks++; if (rec.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", rec.size()); end
    else begin
      checks++; if (rec[0] !== 32'hA || rec[1] !== 32'hB || rec[2] !== 32'hC) begin
        errors++; $display("FAIL bp_order got %h %h %h want a b c", rec[0], rec[1], rec[2]); end
    end
    checks++; if (cnt0_o !== 4'd4) begin errors++; $display("FAIL bp_stall_after got %0d want 4", cnt0_o); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h1, 32'h300, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h2, 32'h304, 1'b1);
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL fl_full got rdy=%b want 0", rdy0); end
    flush_i = 1'b1;
    drive(1'b1, 32'hDD, 32'h308, 1'b1);
    @(negedge clk);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    checks++; if (vld0 !== 1'b0 || o0_we !== 1'b0 || rdy0 !== 1'b1 || obs0 !== BUB) begin
      errors++; $display("FAIL fl_skid got v=%b we=%b rdy=%b pl=%h want bubble", vld0, o0_we, rdy0, obs0); end
    checks++; if (vld1 !== 1'b0 || o1_we !== 1'b0 || rdy1 !== 1'b1 || obs1 !== BUB) begin
      errors++; $display("FAIL fl_single got v=%b we=%b rdy=%b pl=%h want bubble", vld1, o1_we, rdy1, obs1); end
    checks++; if (cnt0_o !== 4'd2) begin errors++; $display("FAIL fl_stall got %0d want 2", cnt0_o); end
    out_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++; if (vld0 !== 1'b0 || vld1 !== 1'b0 || o0_op1 === 32'hDD) begin
        errors++; $display("FAIL fl_ghost got v=%b%b op1=%h want no output", vld0, vld1, o0_op1); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 32'h55, 32'h400, 1'b1);
    @(negedge clk);
    in_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++; if (cnt0_o !== 4'((k < 15) ? k : 15) || o0_op1 !== 32'h55 || vld0 !== 1'b1) begin
        errors++; $display("FAIL sat[%0d] got cnt=%0d op1=%h v=%b want cnt=%0d", k, cnt0_o, o0_op1, vld0, (k < 15) ? k : 15); end
    end
    checks++; if (cnt1_o !== 16'd20) begin errors++; $display("FAIL sat_wide got %0d want 20", cnt1_o); end
  endtask

  task automatic test_no_skid();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 32'hA + 32'(k), 32'h500 + 32'(4 * k), 1'b1);
      out_ready_i = (k >= 6);
      #1;
      checks++; if (rdy1 !== (!vld1 || out_ready_i)) begin
        errors++; $display("FAIL noskid_rdy[%0d] got %b want %b", k, rdy1, (!vld1 || out_ready_i)); end
      @(negedge clk);
      checks++; if (obs1 !== exp_out1()) begin errors++; $display("FAIL noskid_pl[%0d] got %h want %h", k, obs1, exp_out1()); end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++; if (obs0 !== exp_out0() || vld0 !== (q0.size() > 0) || rdy0 !== exp_rdy0()) begin
        errors++; $display("FAIL rnd_skid[%0d] got v=%b rdy=%b pl=%h want %h", i, vld0, rdy0, obs0, exp_out0()); end
      checks++; if (obs1 !== exp_out1() || vld1 !== (q1.size() > 0) || rdy1 !== exp_rdy1()) begin
        errors++; $display("FAIL rnd_single[%0d] got v=%b rdy=%b pl=%h want %h", i, vld1, rdy1, obs1, exp_out1()); end
      checks++; if (cnt0_o !== 4'(mcnt0) || cnt1_o !== 16'(mcnt1)) begin
        errors++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, cnt0_o, cnt1_o, mcnt0, mcnt1); end
      checks++; if (((o0_we & ~vld0) | (o1_we & ~vld1)) !== 1'b0) begin
        errors++; $display("FAIL rnd_we_inv[%0d] got we=%b%b v=%b%b", i, o0_we, o1_we, vld0, vld1); end
      if (i == 200) begin
        #2 rst_i = 1'b0;
        #1;
        checks++; if (vld0 !== 1'b0 || vld1 !== 1'b0 || cnt0_o !== 4'd0 || obs0 !== BUB) begin
          errors++; $display("FAIL rnd_async_rst got v=%b%b cnt=%0d pl=%h want empty", vld0, vld1, cnt0_o, obs0); end
        @(negedge clk);
        rst_i = 1'b1;
      end
      drive($urandom_range(0, 9) < 6, $urandom, $urandom, 1'($urandom_range(0, 1)));
      out_ready_i = $urandom_range(0, 9) < 7;
      flush_i     = $urandom_range(0, 99) < 4;
    end
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_no_skid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
